// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
//   Shared types and constants for the branch predictor.
//   - bp_state_e      : 2-bit saturating counter state (SNT/WNT/WT/ST)
//   - BP_INDEX_BITS   : default log2 of the number of table entries
//   - BP_RESET_STATE  : value every table entry takes on reset
//   - sat_inc32       : 32-bit increment that sticks at all-ones
//   - bp_is_taken     : prediction derived from a counter state
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'd0,
    BP_WNT = 2'd1,
    BP_WT  = 2'd2,
    BP_ST  = 2'd3
  } bp_state_e;

  localparam int          BP_INDEX_BITS  = 6;
  localparam bp_state_e   BP_RESET_STATE = BP_WNT;
  localparam logic [31:0] BP_COUNT_MAX   = 32'hFFFF_FFFF;

  // Statistics counters hold at the maximum instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == BP_COUNT_MAX) ? value : value + 32'd1;
  endfunction

  // WT and ST both have the MSB set, so the MSB alone is the prediction.
  function automatic logic bp_is_taken(input bp_state_e state);
    return state[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//   Groups the fetch-side prediction lookup, the decode-side resolution bus
//   and the result/statistics outputs of the branch predictor.
//   Modports:
//     master : the pipeline side (drives fetch_pc and the resolve_* bus)
//     slave  : the predictor itself
//   Handshake: resolve_valid is a single-cycle qualifier with no ready; the
//   predictor always accepts. resolve_* fields are only meaningful while
//   resolve_valid=1, and the caller has already gated it with stall.
//   mispredict is a registered one-cycle pulse; redirect_pc is meaningful
//   only while mispredict=1.
// -----------------------------------------------------------------------------
interface branch_predictor_if;

  logic [31:0] fetch_pc;
  logic        predict_taken;

  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_predicted;
  logic [31:0] resolve_target;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output fetch_pc,
    input  predict_taken,
    output resolve_valid,
    output resolve_pc,
    output resolve_taken,
    output resolve_predicted,
    output resolve_target,
    input  mispredict,
    input  redirect_pc,
    input  branch_count,
    input  mispredict_count
  );

  modport slave (
    input  fetch_pc,
    output predict_taken,
    input  resolve_valid,
    input  resolve_pc,
    input  resolve_taken,
    input  resolve_predicted,
    input  resolve_target,
    output mispredict,
    output redirect_pc,
    output branch_count,
    output mispredict_count
  );

endinterface

// File: rtl/bp_counter2.sv
// -----------------------------------------------------------------------------
// bp_counter2
//   Pure next-state function of one 2-bit saturating counter.
//   Ports:
//     state : current counter state
//     taken : resolved branch outcome (1 = taken)
//     next  : counter state after training with that outcome
//   Taken moves one step toward ST, not-taken one step toward SNT; both ends
//   saturate.
// -----------------------------------------------------------------------------
module bp_counter2
  import branch_predictor_pkg::*;
(
  input  bp_state_e state,
  input  logic      taken,
  output bp_state_e next
);

  always_comb begin
    next = state;
    if (taken) begin
      case (state)
        BP_SNT:  next = BP_WNT;
        BP_WNT:  next = BP_WT;
        BP_WT:   next = BP_ST;
        BP_ST:   next = BP_ST;
        default: next = BP_RESET_STATE;
      endcase
    end else begin
      case (state)
        BP_SNT:  next = BP_SNT;
        BP_WNT:  next = BP_SNT;
        BP_WT:   next = BP_WNT;
        BP_ST:   next = BP_WT;
        default: next = BP_RESET_STATE;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped, tagless table of 2-bit saturating counters indexed by
//   pc[INDEX_BITS+1:2]. Provides a combinational prediction for the PC in
//   Fetch, trains on branches resolved in Decode, and raises a registered
//   one-cycle mispredict pulse with the correct next PC.
//   Ports:
//     clk    : rising-edge clock for all state
//     reset  : synchronous, active-high; table entries -> WNT, outputs -> 0
//     bus    : branch_predictor_if.slave (fetch lookup, resolve bus,
//              mispredict/redirect, branch and mispredict statistics)
//   Parameters:
//     INDEX_BITS : log2 of the number of table entries
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_predictor_if.slave     bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bp_state_e             table_q [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] resolve_idx;
  bp_state_e             train_cur;
  bp_state_e             train_next;

  logic                  miss;
  logic [31:0]           fall_through_pc;
  logic [31:0]           correct_pc;

  logic                  mispredict_q;
  logic [31:0]           redirect_pc_q;
  logic [31:0]           branch_count_q;
  logic [31:0]           mispredict_count_q;

  // ---------------------------------------------------------------------------
  // Prediction: plain table read. No bypass from a same-cycle training write,
  // so a colliding fetch sees the pre-update counter.
  // ---------------------------------------------------------------------------
  assign fetch_idx         = bus.fetch_pc[INDEX_BITS+1:2];
  assign bus.predict_taken = bp_is_taken(table_q[fetch_idx]);

  // Instruction-alignment bits and the tag-less upper bits never select an
  // entry; aliased PCs share a counter by design.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{bus.fetch_pc[31:INDEX_BITS+2], bus.fetch_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Training: one counter is read, stepped and written back per resolve.
  // ---------------------------------------------------------------------------
  assign resolve_idx = bus.resolve_pc[INDEX_BITS+1:2];
  assign train_cur   = table_q[resolve_idx];

  bp_counter2 u_counter (
    .state (train_cur),
    .taken (bus.resolve_taken),
    .next  (train_next)
  );

  // ---------------------------------------------------------------------------
  // Resolution: the redirect follows the actual outcome, not the prediction
  // stored in the table. The fall-through add wraps modulo 2^32.
  // ---------------------------------------------------------------------------
  assign miss            = bus.resolve_taken ^ bus.resolve_predicted;
  assign fall_through_pc = bus.resolve_pc + 32'd4;
  assign correct_pc      = bus.resolve_taken ? bus.resolve_target : fall_through_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      // A resolve arriving with reset is discarded entirely.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= BP_RESET_STATE;
      end
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= 32'd0;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      // Pulse tracks the current cycle only, so back-to-back misses each
      // produce their own pulse and an idle cycle clears it.
      mispredict_q <= bus.resolve_valid & miss;
      if (bus.resolve_valid) begin
        table_q[resolve_idx] <= train_next;
        redirect_pc_q        <= correct_pc;
        branch_count_q       <= sat_inc32(branch_count_q);
        if (miss) begin
          mispredict_count_q <= sat_inc32(mispredict_count_q);
        end
      end
    end
  end

  assign bus.mispredict       = mispredict_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed scenarios followed by randomized traffic, checked against a
//   behavioural model: an integer array of 0..3 confidence levels, a
//   prediction of "level >= 2", and expected pulse/redirect/count values.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int IB      = 6;
  localparam int ENTRIES = 64;

  logic clk;
  logic reset;

  branch_predictor_if bp_if ();

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bp_if)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int          model_tbl [ENTRIES];
  logic        exp_mp;
  logic [31:0] exp_rd;
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  int total = 0;
  int bad   = 0;

  function automatic int model_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
    return (model_tbl[model_idx(pc)] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model_tbl[i] = 1;
    exp_mp = 1'b0;
    exp_rd = 32'd0;
    exp_bc = 32'd0;
    exp_mc = 32'd0;
  endtask

  task automatic model_resolve(input logic rv, input logic [31:0] rpc,
                               input logic rt, input logic rp,
                               input logic [31:0] tgt);
    int k;
    if (rv) begin
      k = model_idx(rpc);
      if (rt) model_tbl[k] = (model_tbl[k] < 3) ? model_tbl[k] + 1 : 3;
      else    model_tbl[k] = (model_tbl[k] > 0) ? model_tbl[k] - 1 : 0;
      exp_mp = (rt != rp);
      exp_rd = rt ? tgt : rpc + 32'd4;
      if (exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 32'd1;
      if (rt != rp && exp_mc != 32'hFFFF_FFFF) exp_mc = exp_mc + 32'd1;
    end else begin
      exp_mp = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":mispredict"}, {31'd0, bp_if.mispredict}, {31'd0, exp_mp});
    check({tag, ":redirect"},   bp_if.redirect_pc,         exp_rd);
    check({tag, ":bcount"},     bp_if.branch_count,        exp_bc);
    check({tag, ":mcount"},     bp_if.mispredict_count,    exp_mc);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers: called #1 after a rising edge; drive, check the combinational
  // prediction, take one edge, then check the registered outputs.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rt,
                       input logic rp, input logic [31:0] tgt, input logic [31:0] fpc);
    bp_if.resolve_valid     = rv;
    bp_if.resolve_pc        = rpc;
    bp_if.resolve_taken     = rt;
    bp_if.resolve_predicted = rp;
    bp_if.resolve_target    = tgt;
    bp_if.fetch_pc          = fpc;
  endtask

  task automatic cycle(input string tag, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic rp, input logic [31:0] tgt,
                       input logic [31:0] fpc);
    drive(rv, rpc, rt, rp, tgt, fpc);
    #1;
    check({tag, ":pred"}, {31'd0, bp_if.predict_taken}, {31'd0, model_pred(fpc)});
    @(posedge clk);
    model_resolve(rv, rpc, rt, rp, tgt);
    #1;
    check_outputs(tag);
  endtask

  task automatic resolve(input string tag, input logic [31:0] rpc, input logic rt,
                         input logic rp, input logic [31:0] tgt);
    cycle(tag, 1'b1, rpc, rt, rp, tgt, rpc);
  endtask

  task automatic idle(input string tag, input logic [31:0] fpc);
    cycle(tag, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, fpc);
  endtask

  // Reset together with a mispredicting resolve: the resolve must vanish.
  task automatic reset_with_resolve(input string tag, input logic [31:0] rpc);
    drive(1'b1, rpc, 1'b1, 1'b0, 32'h1234_5678, rpc);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, rpc);
    check_outputs(tag);
    #1;
    check({tag, ":pred_wnt"}, {31'd0, bp_if.predict_taken}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] r_pc;
  logic [31:0] r_fpc;
  logic [31:0] r_tgt;
  logic        r_rv;
  logic        r_rt;
  logic        r_rp;

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;

    // Reset state
    bp_if.fetch_pc = 32'h0040_0000;
    #1;
    check("reset:pred",  {31'd0, bp_if.predict_taken}, 32'd0);
    check("reset:mp",    {31'd0, bp_if.mispredict},    32'd0);
    check("reset:rd",    bp_if.redirect_pc,            32'd0);
    check("reset:bc",    bp_if.branch_count,           32'd0);
    check("reset:mc",    bp_if.mispredict_count,       32'd0);

    // Two mispredicted taken resolves at the same PC
    resolve("bt1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040);
    check("bt1:mp_lit", {31'd0, bp_if.mispredict}, 32'd1);
    check("bt1:rd_lit", bp_if.redirect_pc, 32'h0040_0040);
    resolve("bt2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0040);
    check("bt2:mp_lit", {31'd0, bp_if.mispredict}, 32'd1);
    idle("bt_after", 32'h0040_0010);
    check("bt:pred_lit", {31'd0, bp_if.predict_taken}, 32'd1);
    check("bt:bc_lit",   bp_if.branch_count,     32'd2);
    check("bt:mc_lit",   bp_if.mispredict_count, 32'd2);
    check("bt:mp_drop",  {31'd0, bp_if.mispredict}, 32'd0);
    check("bt:rd_hold",  bp_if.redirect_pc, 32'h0040_0040);

    // Saturation at ST, then two not-taken steps
    for (int i = 0; i < 5; i++) resolve("sat_t", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0100);
    resolve("sat_nt1", 32'h0040_0030, 1'b0, 1'b1, 32'h0040_0100);
    idle("sat_chk1", 32'h0040_0030);
    check("sat:pred_after1", {31'd0, bp_if.predict_taken}, 32'd1);
    resolve("sat_nt2", 32'h0040_0030, 1'b0, 1'b1, 32'h0040_0100);
    idle("sat_chk2", 32'h0040_0030);
    check("sat:pred_after2", {31'd0, bp_if.predict_taken}, 32'd0);

    // Fall-through redirect wraps around
    resolve("wrap", 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_1000);
    check("wrap:rd_lit", bp_if.redirect_pc, 32'h0000_0000);
    check("wrap:mp_lit", {31'd0, bp_if.mispredict}, 32'd1);

    // Same-cycle collision: no write-to-read bypass
    drive(1'b1, 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0200, 32'h0040_0020);
    #1;
    check("coll:pred_pre", {31'd0, bp_if.predict_taken}, 32'd0);
    @(posedge clk);
    model_resolve(1'b1, 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0200);
    #1;
    check_outputs("coll");
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0040_0020);
    #1;
    check("coll:pred_post", {31'd0, bp_if.predict_taken}, 32'd1);
    @(posedge clk);
    model_resolve(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;

    // Reset concurrent with a missing resolve
    reset_with_resolve("rst_mid", 32'h0040_0010);

    // Randomized traffic with aliasing through the upper PC bits
    for (int n = 0; n < 600; n++) begin
      r_rv  = ($urandom_range(0, 3) != 0);
      r_pc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      r_fpc = ($urandom_range(0, 1) == 1) ? r_pc
                                          : (($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2));
      r_rt  = 1'($urandom_range(0, 1));
      r_rp  = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1)) : model_pred(r_pc);
      r_tgt = $urandom;
      if (n % 150 == 149) reset_with_resolve("rnd_rst", r_pc);
      else cycle("rnd", r_rv, r_pc, r_rt, r_rp, r_tgt, r_fpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and resolution unit for the TungstenHammer pipelined MIPS core. It supplies a taken/not-taken prediction for the instruction in Fetch from a direct-mapped table of 2-bit saturating counters. It accepts the resolved outcome from the branch comparer in Decode, trains the table, and raises a one-cycle registered mispredict/redirect to the hazard unit and the PC mux. It also keeps branch and mispredict statistics for the simulation testbench.

## Interface
- INDEX_BITS, 6, log2 of table entries (64); index = pc[INDEX_BITS+1:2]
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- fetch_pc  in  32  PC of the instruction currently in Fetch
- predict_taken  out  1  combinational prediction for fetch_pc (counter MSB)
- resolve_valid  in  1  Decode holds a resolved conditional branch this cycle; already gated by stall in the caller
- resolve_pc  in  32  PC of the resolving branch
- resolve_taken  in  1  comparer result (1 = condition met)
- resolve_predicted  in  1  prediction carried down the pipeline with that branch
- resolve_target  in  32  computed branch target
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  32  registered correct next PC; valid when mispredict=1
- branch_count  out  32  resolved branches, saturating
- mispredict_count  out  32  mispredictions, saturating

## Operation
- Each table entry has four states: SNT=0, WNT=1, WT=2, ST=3. Prediction is taken when the state is WT or ST.
- Training, on a rising edge with resolve_valid=1, at entry resolve_pc[INDEX_BITS+1:2]:
  - taken: SNT→WNT→WT→ST→ST
  - not taken: ST→WT→WNT→SNT→SNT
- When resolve_valid=0, no entry changes.
- Resolution, when resolve_valid=1:
  - miss = resolve_taken XOR resolve_predicted
  - On the next edge, mispredict is set to miss.
  - On the next edge, redirect_pc is set to resolve_target if resolve_taken=1, else resolve_pc+4 (32-bit, wraps modulo 2^32).
- When resolve_valid=0, mispredict is cleared on the next edge and redirect_pc holds its last value.
- Statistics:
  - branch_count increments on each resolve_valid.
  - mispredict_count increments on each miss.
  - Both hold at 0xFFFFFFFF; no wrap.
- The table is tagless. Aliased PCs share an entry.
- Non-branch PCs still produce a prediction. Fetch ignores it unless the instruction is a branch.
- The redirect is driven by the actual outcome, never by the stored prediction.

## Timing
- Reset, effective at the first edge with reset=1:
  - every table entry becomes WNT
  - mispredict=0, redirect_pc=0, branch_count=0, mispredict_count=0
  - predict_taken therefore reads 0 the cycle after reset
- Reset asserted mid-operation:
  - A concurrent resolve is discarded: no training, no pulse, no count.
  - A pulse already on mispredict drops at that edge.
- Prediction latency is 0 cycles: combinational table read.
- Training latency is 1 edge.
- Same-cycle collision (fetch_pc and resolve_pc index the same entry): predict_taken reflects the pre-update value. There is no write-to-read bypass.
- Mispredict latency is 1 cycle after resolve_valid. The pulse is exactly 1 cycle wide unless resolve_valid is asserted with a miss on consecutive cycles; each such cycle produces its own pulse.
- Back-to-back resolves to the same entry train cumulatively, one step per edge.

## Structure
- include/mips.h gains:
  - `BP_SNT, `BP_WNT, `BP_WT, `BP_ST (2-bit)
  - `BP_INDEX_BITS default
  - the reset state `BP_RESET_STATE = `BP_WNT
- Sub-module bp_counter2: pure next-state function for one 2-bit saturating counter (inputs state and taken, output next). It is instantiated once for the entry being trained.
- The table is a reg array of 2**INDEX_BITS × 2 bits, cleared in a for-loop under reset.

## Test plan
- Reset, then fetch_pc=0x00400000 → predict_taken=0. Check: counts 0, mispredict=0, redirect_pc=0.
- Two resolves at pc=0x00400010, taken=1, predicted=0, target=0x00400040:
  - 1st resolve: mispredict pulses and redirect_pc=0x00400040.
  - 2nd resolve: mispredict pulses again.
  - Afterwards fetch_pc=0x00400010 → predict_taken=1.
  - branch_count=2, mispredict_count=2.
- Saturation: 5× taken at one PC, then 1× not-taken → prediction stays 1. A 2nd not-taken → prediction 0.
- Fall-through redirect: resolve pc=0xFFFFFFFC, taken=0, predicted=1 → redirect_pc=0x00000000 (wrap), mispredict=1.
- Collision: fetch_pc=resolve_pc=0x00400020, entry WNT, taken=1 → predict_taken=0 that cycle, 1 the next cycle.
- Reset asserted in the same cycle as a missing resolve → no pulse, counts 0, entry back to WNT.
